sample_delay_var: RTL

Programmable sample-domain delay line for 48-bit SDR sample words, built on a circular buffer with write and read pointers. It complements the fixed clock-count delay stages in the datapath. The delay is counted in accepted samples (`valid_i` strobes), not clocks, and can be reprogrammed at run time. It aligns two sample paths whose relative latency is known only after configuration, for example I/Q against a control or gain path.

---
 rtl/sdr_pkg.sv | 13 +
 rtl/sdp_ram.sv | 23 ++
 rtl/sample_delay_var.sv | 100 ++++++++++
 3 files changed

// File: rtl/sdr_pkg.sv
// Shared SDR sample types and the state encoding used by the variable sample delay line.
package sdr_pkg;

  localparam int SAMPLE_W = 48;

  typedef logic [SAMPLE_W-1:0] sample_t;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } dly_state_e;

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one synchronous write port, one asynchronous read port, no array reset.
module sdp_ram #(
  parameter int W     = 48,
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sample_delay_var.sv
// Programmable delay line counted in accepted samples, built on a circular buffer.
// valid_i/data_i form a strobe-only stream (no backpressure); valid_o is valid_i one clock later.
module sample_delay_var
  import sdr_pkg::*;
#(
  parameter int DATA_W        = SAMPLE_W,
  parameter int AW            = 5,
  parameter int DEFAULT_DELAY = 15
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              load_i,
  input  logic [AW-1:0]     delay_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic              primed_o
);

  localparam logic [AW-1:0] DEF_DLY   = AW'(DEFAULT_DELAY);
  localparam logic [AW-1:0] FILL_MAX  = '1;
  localparam dly_state_e    RST_STATE = (DEFAULT_DELAY == 0) ? ST_RUN : ST_FILL;

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     fill_cnt_q, fill_cnt_d;
  logic [AW-1:0]     delay_q, delay_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  dly_state_e        state_q, state_d;

  logic [AW-1:0]     eff_delay;
  logic [AW-1:0]     eff_fill;
  logic [AW-1:0]     rd_addr;
  logic [DATA_W-1:0] rd_data;

  sdp_ram #(
    .W     (DATA_W),
    .DEPTH (2**AW),
    .AW    (AW)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (valid_i),
    .waddr_i (wr_ptr_q),
    .wdata_i (data_i),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

  // A load in the same cycle as a strobe applies its delay and empty fill to that strobe.
  always_comb begin
    eff_delay  = load_i ? delay_i : delay_q;
    eff_fill   = load_i ? '0 : fill_cnt_q;
    rd_addr    = wr_ptr_q - eff_delay;
    wr_ptr_d   = wr_ptr_q;
    fill_cnt_d = eff_fill;
    delay_d    = eff_delay;
    valid_d    = valid_i;
    data_d     = data_q;
    if (valid_i) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      if (eff_fill != FILL_MAX) fill_cnt_d = eff_fill + AW'(1);
      if (eff_delay == '0)            data_d = data_i;
      else if (eff_fill >= eff_delay) data_d = rd_data;
      else                            data_d = '0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FILL: if (fill_cnt_d >= delay_d) state_d = ST_RUN;
      ST_RUN:  if (load_i && (delay_i != '0) && (fill_cnt_d < delay_d)) state_d = ST_FILL;
      default: state_d = ST_FILL;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      fill_cnt_q <= '0;
      delay_q    <= DEF_DLY;
      valid_q    <= 1'b0;
      data_q     <= '0;
      state_q    <= RST_STATE;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      fill_cnt_q <= fill_cnt_d;
      delay_q    <= delay_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      state_q    <= state_d;
    end
  end

  assign valid_o  = valid_q;
  assign data_o   = data_q;
  assign primed_o = (state_q == ST_RUN);

endmodule
